// File: rtl/bus_pkg.sv
// Shared definitions for the burst memory slave: response codes, {addr,len,id}
// field layout helpers and the read/write engine state types.
package bus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_ID_W   = 4;

    // The id sits in the low bits, len above it, addr on top.
    function automatic int fieldLenOff(input int idW);
        return idW;
    endfunction

    function automatic int fieldAddrOff(input int idW, input int lenW);
        return idW + lenW;
    endfunction

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address/beat tracker: latches start address and length, steps the
// address with wrap and flags the final beat of the burst.
module burst_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;

    // Address wraps naturally through the ADDR_W-bit adder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_len  <= i_len;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt + LEN_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == r_len);

endmodule

// File: rtl/burst_mem_slave.sv
// Byte-wide burst slave with independent read and write engines over a
// register-file memory. Define BURST_MEM_SLAVE_PERF_CNT_EN for burst counters.
module burst_mem_slave
    import bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ID_W   = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [ADDR_W+LEN_W+ID_W-1:0] AR,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [DATA_W-1:0]         RDATA,
    output logic                      RLAST,
    output logic [ID_W-1:0]           RID,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [ADDR_W+LEN_W+ID_W-1:0] AW,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [DATA_W-1:0]         WDATA,
    input  logic                      WLAST,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [1:0]                BRESP,
    output logic [ID_W-1:0]           BID,
    output logic                      RIDLE,
    output logic                      WIDLE
`ifdef BURST_MEM_SLAVE_PERF_CNT_EN
    ,
    output logic [15:0]               RD_BURSTS,
    output logic [15:0]               WR_BURSTS
`endif
);

    localparam int LEN_OFF  = fieldLenOff(ID_W);
    localparam int ADDR_OFF = fieldAddrOff(ID_W, LEN_W);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    rd_state_t         r_rstate, w_rnext;
    wr_state_t         r_wstate, w_wnext;
    logic [ID_W-1:0]   r_rid, r_bid;
    logic [1:0]        r_bresp;
    logic [ADDR_W-1:0] w_raddr, w_waddr;
    logic              w_rlast, w_wlast;
    logic              w_rload, w_rstep, w_wload, w_wbeat, w_wend;

    assign w_rload = ARVALID & ARREADY;
    assign w_rstep = RVALID & RREADY;
    assign w_wload = AWVALID & AWREADY;
    assign w_wbeat = WVALID & WREADY;
    assign w_wend  = w_wbeat & (WLAST | w_wlast);

    burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_rload),
        .i_step (w_rstep),
        .i_addr (AR[ADDR_OFF +: ADDR_W]),
        .i_len  (AR[LEN_OFF +: LEN_W]),
        .o_addr (w_raddr),
        .o_last (w_rlast)
    );

    burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_wload),
        .i_step (w_wbeat),
        .i_addr (AW[ADDR_OFF +: ADDR_W]),
        .i_len  (AW[LEN_OFF +: LEN_W]),
        .o_addr (w_waddr),
        .o_last (w_wlast)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
            r_rid    <= '0;
            r_bid    <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rnext;
            r_wstate <= w_wnext;
            if (w_rload) r_rid <= AR[ID_W-1:0];
            if (w_wload) begin
                r_bid   <= AW[ID_W-1:0];
                r_bresp <= RESP_OKAY;
            end else if (w_wend) begin
                // Ending on exactly one of WLAST / counter==len is an early or missing last.
                r_bresp <= (WLAST ^ w_wlast) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_comb begin
        w_rnext = r_rstate;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) w_rnext = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY && w_rlast) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    always_comb begin
        w_wnext = r_wstate;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) w_wnext = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (w_wend) w_wnext = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    // Memory has no reset; a same-cycle read of the written address sees old data.
    always_ff @(posedge clk) begin
        if (w_wbeat) r_mem[w_waddr] <= WDATA;
    end

    assign RDATA = RVALID ? r_mem[w_raddr] : '0;
    assign RLAST = RVALID & w_rlast;
    assign RID   = r_rid;
    assign BRESP = r_bresp;
    assign BID   = r_bid;
    assign RIDLE = (r_rstate == R_IDLE);
    assign WIDLE = (r_wstate == W_IDLE);

`ifdef BURST_MEM_SLAVE_PERF_CNT_EN
    logic [15:0] r_rd_bursts, r_wr_bursts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_bursts <= '0;
            r_wr_bursts <= '0;
        end else begin
            if (w_rstep && w_rlast) r_rd_bursts <= r_rd_bursts + 16'd1;
            if (BVALID && BREADY)   r_wr_bursts <= r_wr_bursts + 16'd1;
        end
    end

    assign RD_BURSTS = r_rd_bursts;
    assign WR_BURSTS = r_wr_bursts;
`else
`endif

endmodule

// File: doc/burst_mem_slave.md
Name: burst_mem_slave

Overview:
- Downstream stage of the bus master instances (ALU/MEM/IO): a byte-wide burst slave that answers the master's address, data and response channels.
- Holds a 2**ADDR_W x DATA_W register-file memory.
- Independent read and write engines; each reports RIDLE/WIDLE, and the controller watches these to retire and re-dispatch queued opcodes.

Parameters:
- ADDR_W, 8, byte address width; memory depth 2**ADDR_W
- DATA_W, 8, beat width
- LEN_W, 4, burst length field; beats = len+1
- ID_W, 4, transaction ID width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- AR  in  ADDR_W+LEN_W+ID_W  {addr, len, id}
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RDATA  out  DATA_W  read beat
- RLAST  out  1  final read beat
- RID  out  ID_W  ID of current read burst
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AW  in  ADDR_W+LEN_W+ID_W  {addr, len, id}
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WDATA  in  DATA_W  write beat
- WLAST  in  1  master marks final beat
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BRESP  out  2  00 OKAY, 10 SLVERR
- BID  out  ID_W  ID of responded write
- RIDLE  out  1  read engine in R_IDLE
- WIDLE  out  1  write engine in W_IDLE

Behaviour:
- Reset (rst=0, async): both FSMs go idle.
  - Outputs: ARREADY=1, AWREADY=1, RIDLE=1, WIDLE=1; RVALID, RLAST, WREADY, BVALID = 0; RDATA, RID, BRESP, BID = 0.
  - Memory is not reset; contents persist.
  - Reset mid-burst abandons the burst with no response.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch addr/len/id, beat counter=0, go to R_DATA.
  - R_DATA: RVALID=1 from the cycle after the AR handshake. ARREADY=0, RIDLE=0.
  - RDATA=mem[raddr]. RDATA/RID/RLAST hold stable while RVALID & !RREADY.
  - Each RVALID&RREADY: raddr+1 modulo 2**ADDR_W, counter+1.
  - RLAST=1 when counter==len. That handshake returns the FSM to R_IDLE, so ARREADY=1 on the next cycle (one idle cycle minimum between bursts).
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch addr/len/id, clear error, go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes WDATA to mem[waddr]; waddr wraps modulo depth.
  - Burst terminates on the first beat where WLAST=1 or counter==len.
  - SLVERR if WLAST=1 with counter<len (early), or counter==len with WLAST=0 (missing). OKAY otherwise.
  - W_RESP: BVALID=1 with BRESP/BID held until BREADY, then W_IDLE.
  - WIDLE=0 from the cycle after the AW handshake through the BVALID&BREADY cycle.
- The read and write engines run concurrently.
- Same-cycle write and read to the same address: the read beat returns the old data; the new data is visible from the next cycle.
- Address wrap: a burst starting at 0xFE with len=3 touches 0xFE, 0xFF, 0x00, 0x01.
- No outstanding-transaction queue: exactly one read and one write in flight.

Optional Feature:
- Macro: BURST_MEM_SLAVE_PERF_CNT_EN.
- Defined: adds outputs RD_BURSTS[15:0] and WR_BURSTS[15:0].
  - Reset to 0.
  - RD_BURSTS increments on the RLAST handshake; WR_BURSTS increments on the BVALID&BREADY handshake.
  - Both wrap at 0xFFFF->0.
  - WR_BURSTS counts SLVERR responses too.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bus_pkg:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - field-slice widths and offsets for {addr,len,id};
  - read/write state enums.
- One sub-module, burst_addr_gen: latches addr/len, increments the address with wrap and the beat counter, and flags last. Instantiated twice, once per engine.

Test Plan:
- Write AW={0x01,len=7,id=3}, WDATA 1..8, WLAST on beat 8, BREADY=1 -> BVALID one cycle after the last W handshake, BRESP=00, BID=3, mem[0x01..0x08]=1..8, WIDLE rises the cycle after the B handshake.
- Then AR={0x01,7,id=5} with RREADY=1 -> RVALID the cycle after the AR handshake, RDATA 1..8 on consecutive cycles, RLAST only on 8, RID=5.
- Read with RREADY toggling 1,0,1,0 -> RDATA/RLAST stable during stalls, 8 beats still delivered in order, ARREADY=0 until the cycle after RLAST.
- Write len=3 with WLAST on beat 2 -> BRESP=10 and only 2 bytes written. Write len=1 with no WLAST -> after 2 beats BRESP=10.
- Write AW addr 0xFE len=3 data A,B,C,D, then read it back -> mem[0xFE]=A, [0xFF]=B, [0x00]=C, [0x01]=D.
- Drop rst mid-read (beat 3 of 8) -> RVALID=0, ARREADY=1, RIDLE=1 immediately. With PERF_CNT_EN, RD_BURSTS=0 after reset and 1 after one complete read.
